// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory-wait stalls, branch flush sequencing,
// load-use stalls and operand forwarding. Define FORWARD_EN to enable the forwarding muxes.
module pipeline_hazard_ctrl #(
   parameter int unsigned BR_FLUSH_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT     = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] RA1D,
   input  logic [3:0] RA2D,
   input  logic [3:0] RA1E,
   input  logic [3:0] RA2E,
   input  logic [3:0] WA3E,
   input  logic [3:0] WA3M,
   input  logic [3:0] WA3W,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       BranchTakenE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MemErr,
   output logic [1:0] State
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_BRFLUSH = 2'b01,
      ST_MEMWAIT = 2'b10,
      ST_BAD     = 2'b11
   } state_e;

   localparam logic [2:0] BR_RELOAD = 3'(BR_FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic       prior_br_q, prior_br_d;
   logic [2:0] br_cnt_q, br_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_err_q, mem_err_d;

   logic       mem_wait, load_use, resuming, in_br;
   logic       stall_fd, stall_em, flush_d, flush_e, flush_w;
   logic [1:0] fwd_a, fwd_b;
   logic       d_hit_e;

   assign mem_wait = MemReqM & ~MemReadyM;
   assign d_hit_e  = (WA3E == RA1D) || (WA3E == RA2D);

`ifdef FORWARD_EN
   assign load_use = MemtoRegE & d_hit_e;

   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (RegWriteM && (WA3M == RA1E))      fwd_a = 2'b10;
      else if (RegWriteW && (WA3W == RA1E)) fwd_a = 2'b01;
      if (RegWriteM && (WA3M == RA2E))      fwd_b = 2'b10;
      else if (RegWriteW && (WA3W == RA2E)) fwd_b = 2'b01;
   end
`else
   logic d_hit_m;
   logic unused_fwd_inputs;

   // Without bypass paths every pending writer in E or M must drain before Decode reads.
   assign d_hit_m  = (WA3M == RA1D) || (WA3M == RA2D);
   assign load_use = ((MemtoRegE | RegWriteE) & d_hit_e) | (RegWriteM & d_hit_m);
   assign fwd_a    = 2'b00;
   assign fwd_b    = 2'b00;
   assign unused_fwd_inputs = ^{RA1E, RA2E, WA3W, RegWriteW};
`endif

   // While MEMWAIT is released (no wait this cycle) the block behaves as its saved state.
   assign resuming = (state_q == ST_MEMWAIT);
   assign in_br    = (state_q == ST_BRFLUSH) || (resuming && prior_br_q);

   always_comb begin
      state_d    = state_q;
      prior_br_d = prior_br_q;
      br_cnt_d   = br_cnt_q;
      wait_cnt_d = 8'd0;
      mem_err_d  = mem_err_q;
      stall_fd   = 1'b0;
      stall_em   = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_w    = 1'b0;

      if (mem_wait) begin
         stall_fd = 1'b1;
         stall_em = 1'b1;
         flush_w  = 1'b1;
         wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
         if (wait_cnt_d >= TIMEOUT) mem_err_d = 1'b1;
         if (state_q == ST_RUN || state_q == ST_BRFLUSH) begin
            prior_br_d = (state_q == ST_BRFLUSH);
            state_d    = ST_MEMWAIT;
         end else if (state_q == ST_BAD) begin
            state_d = ST_RUN;
         end
      end else if (state_q == ST_BAD) begin
         state_d = ST_RUN;
      end else if (BranchTakenE) begin
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         br_cnt_d = BR_RELOAD;
         state_d  = (BR_RELOAD != 3'd0) ? ST_BRFLUSH : ST_RUN;
      end else if (in_br) begin
         flush_d = 1'b1;
         if (resuming) begin
            state_d = ST_BRFLUSH;
         end else if (br_cnt_q > 3'd1) begin
            br_cnt_d = br_cnt_q - 3'd1;
            state_d  = ST_BRFLUSH;
         end else begin
            br_cnt_d = 3'd0;
            state_d  = ST_RUN;
         end
      end else begin
         state_d = ST_RUN;
         if (load_use) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RUN;
         prior_br_q <= 1'b0;
         br_cnt_q   <= 3'd0;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prior_br_q <= prior_br_d;
         br_cnt_q   <= br_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Control outputs are forced low while reset is held, independent of the clock.
   assign StallF    = reset_n & stall_fd;
   assign StallD    = reset_n & stall_fd;
   assign StallE    = reset_n & stall_em;
   assign StallM    = reset_n & stall_em;
   assign FlushD    = reset_n & flush_d;
   assign FlushE    = reset_n & flush_e;
   assign FlushW    = reset_n & flush_w;
   assign ForwardAE = {2{reset_n}} & fwd_a;
   assign ForwardBE = {2{reset_n}} & fwd_b;
   assign MemErr    = mem_err_q;
   assign State     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (BR=2/TO=4 and BR=3/TO=6) checked every cycle
// against a cycle-level model, plus literal expectations on the first instance.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] RA1D = '0, RA2D = '0, RA1E = '0, RA2E = '0;
   logic [3:0] WA3E = '0, WA3M = '0, WA3W = '0;
   logic       RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
   logic       MemtoRegE = 1'b0, BranchTakenE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;

   logic [13:0] outs [2];

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       sf, sd, se, sm, fd, fe, fw, err;
      logic [1:0] fa, fb, st;
      pipeline_hazard_ctrl #(
         .BR_FLUSH_CYCLES(g == 0 ? 2 : 3),
         .MEM_TIMEOUT    (g == 0 ? 4 : 6)
      ) u_dut (
         .clk(clk), .reset_n(rst_n),
         .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
         .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
         .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
         .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
         .MemReqM(MemReqM), .MemReadyM(MemReadyM),
         .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
         .FlushD(fd), .FlushE(fe), .FlushW(fw),
         .ForwardAE(fa), .ForwardBE(fb), .MemErr(err), .State(st)
      );
      assign outs[g] = {sf, sd, se, sm, fd, fe, fw, fa, fb, err, st};
   end

   // Output vector layout: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, FwdA, FwdB, MemErr, State}
   function automatic logic [13:0] pack(input logic [3:0] stalls, input logic [2:0] flushes,
                                        input logic [1:0] fa, input logic [1:0] fb,
                                        input logic err, input logic [1:0] st);
      return {stalls, flushes, fa, fb, err, st};
   endfunction

   // ---------------- model ----------------
   // flush_rem: FlushD cycles still owed after a taken branch; prev_wait: last cycle was a wait.
   int m_flush_rem [2] = '{0, 0};
   int m_wait_run  [2] = '{0, 0};
   bit m_prev_wait [2] = '{0, 0};
   bit m_err       [2] = '{0, 0};

   function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
`ifdef FORWARD_EN
      if (RegWriteM && WA3M == ra) return 2'b10;
      if (RegWriteW && WA3W == ra) return 2'b01;
`endif
      return 2'b00;
   endfunction

   function automatic logic [13:0] model_outs(input int i);
      logic [3:0] st;
      logic [2:0] fl;
      logic [1:0] sv;
      bit w, hz;
      if (!rst_n) return '0;
      st = '0;
      fl = '0;
      w  = MemReqM && !MemReadyM;
      hz = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
`ifndef FORWARD_EN
      hz = hz || (RegWriteE && (WA3E == RA1D || WA3E == RA2D))
              || (RegWriteM && (WA3M == RA1D || WA3M == RA2D));
`endif
      if (w) begin
         st = 4'b1111;
         fl = 3'b001;
      end else if (BranchTakenE) begin
         fl = 3'b110;
      end else if (m_flush_rem[i] > 0) begin
         fl = 3'b100;
      end else if (hz) begin
         st = 4'b1100;
         fl = 3'b010;
      end
      sv = m_prev_wait[i] ? 2'b10 : (m_flush_rem[i] > 0 ? 2'b01 : 2'b00);
      return {st, fl, fwd_sel(RA1E), fwd_sel(RA2E), m_err[i], sv};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_flush_rem[i] <= 0;
            m_wait_run[i]  <= 0;
            m_prev_wait[i] <= 1'b0;
            m_err[i]       <= 1'b0;
         end else if (MemReqM && !MemReadyM) begin
            m_wait_run[i]  <= (m_wait_run[i] < 255) ? m_wait_run[i] + 1 : 255;
            if (m_wait_run[i] + 1 >= ((i == 0) ? 4 : 6)) m_err[i] <= 1'b1;
            m_prev_wait[i] <= 1'b1;
         end else begin
            m_wait_run[i]  <= 0;
            m_prev_wait[i] <= 1'b0;
            if (BranchTakenE) m_flush_rem[i] <= ((i == 0) ? 2 : 3) - 1;
            else if (m_flush_rem[i] > 0 && !m_prev_wait[i]) m_flush_rem[i] <= m_flush_rem[i] - 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("model_u0", outs[0], model_outs(0));
      check("model_u1", outs[1], model_outs(1));
   end

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
      WA3E = '0; WA3M = '0; WA3W = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
   endtask

   task automatic lit(input string name, input logic [13:0] exp);
      #2;
      check(name, outs[0], exp);
   endtask

   localparam logic [13:0] ZERO = '0;

   // ---------------- stimulus ----------------
   initial begin
      idle();
      #2;
      check("reset_outputs", outs[0], ZERO);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Load into R3 in Execute while Decode reads R3.
      MemtoRegE = 1'b1; WA3E = 4'd3; RA1D = 4'd3; RA2D = 4'd5;
      lit("load_use", pack(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 2'b00));
      next_cycle();
      idle();
      lit("load_use_release", ZERO);
      next_cycle();

      // Single taken branch.
      BranchTakenE = 1'b1;
      lit("branch_c0", pack(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 2'b00));
      next_cycle();
      idle();
      lit("branch_c1", pack(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 2'b01));
      next_cycle();
      lit("branch_done", ZERO);
      next_cycle();
      next_cycle();

      // Branch and load-use together: the branch wins.
      BranchTakenE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd6; RA2D = 4'd6; RA1D = 4'd1;
      lit("branch_vs_loaduse", pack(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 2'b00));
      next_cycle();
      idle();
      // Load-use while flushing Decode is not stalled.
      MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2;
      lit("loaduse_in_brflush", pack(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 2'b01));
      next_cycle();
      idle();
      repeat (3) next_cycle();

      // Branch reload while already flushing.
      BranchTakenE = 1'b1;
      next_cycle();
      lit("branch_reload", pack(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 2'b01));
      next_cycle();
      idle();
      lit("branch_reload_tail", pack(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 2'b01));
      next_cycle();
      lit("branch_reload_done", ZERO);
      repeat (2) next_cycle();

      // Three-cycle memory wait.
      MemReqM = 1'b1; MemReadyM = 1'b0;
      lit("memwait_c0", pack(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2'b00));
      next_cycle();
      lit("memwait_c1", pack(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2'b10));
      next_cycle();
      next_cycle();
      MemReadyM = 1'b1;
      lit("memwait_ready", pack(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 2'b10));
      next_cycle();
      idle();
      lit("memwait_done", ZERO);
      next_cycle();

      // Memory wait in the middle of a branch flush (BRFLUSH counter held).
      BranchTakenE = 1'b1;
      next_cycle();
      idle();
      MemReqM = 1'b1;
      repeat (2) next_cycle();
      MemReadyM = 1'b1;
      lit("brflush_resume", pack(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 2'b10));
      next_cycle();
      idle();
      lit("brflush_after_wait", pack(4'b0000, 3'b100, 2'b00, 2'b00, 1'b0, 2'b01));
      repeat (4) next_cycle();

      // Memory timeout: five wait cycles against MEM_TIMEOUT=4.
      MemReqM = 1'b1; MemReadyM = 1'b0;
      repeat (4) next_cycle();
      lit("timeout_set", pack(4'b1111, 3'b001, 2'b00, 2'b00, 1'b1, 2'b10));
      next_cycle();
      idle();
      next_cycle();
      lit("timeout_sticky", pack(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 2'b00));
      rst_n = 1'b0;
      #1;
      check("timeout_cleared", outs[0], ZERO);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // RAW hazards against plain writers in E and M (stall only without bypass paths).
      RegWriteE = 1'b1; WA3E = 4'd7; RA2D = 4'd7; RA1D = 4'd1;
`ifdef FORWARD_EN
      lit("raw_e", ZERO);
`else
      lit("raw_e", pack(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 2'b00));
`endif
      next_cycle();
      idle();
      RegWriteM = 1'b1; WA3M = 4'd9; RA1D = 4'd9; RA2D = 4'd1;
`ifdef FORWARD_EN
      lit("raw_m", ZERO);
`else
      lit("raw_m", pack(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 2'b00));
`endif
      next_cycle();
      idle();

      // Forwarding selects (RA1D kept away from the writers to avoid stalls).
      RA1D = 4'd15; RA2D = 4'd15; WA3E = 4'd14;
      RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd5; WA3W = 4'd5; RA1E = 4'd5; RA2E = 4'd2;
`ifdef FORWARD_EN
      lit("fwd_mem", pack(4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 2'b00));
`else
      lit("fwd_mem", ZERO);
`endif
      next_cycle();
      RegWriteM = 1'b0; RA2E = 4'd5;
`ifdef FORWARD_EN
      lit("fwd_wb", pack(4'b0000, 3'b000, 2'b01, 2'b01, 1'b0, 2'b00));
`else
      lit("fwd_wb", ZERO);
`endif
      next_cycle();
      idle();
      next_cycle();

      // Branch during a memory wait, then asynchronous reset mid-cycle.
      MemReqM = 1'b1; MemReadyM = 1'b0;
      next_cycle();
      BranchTakenE = 1'b1;
      lit("branch_in_wait", pack(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 2'b10));
      rst_n = 1'b0;
      #1;
      check("async_reset", outs[0], ZERO);
      next_cycle();
      idle();
      rst_n = 1'b1;
      lit("after_reset", ZERO);
      next_cycle();

      // Randomised traffic on a small register space; the model checks every cycle.
      for (int n = 0; n < 400; n++) begin
         RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
         RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
         WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
         WA3W = 4'($urandom_range(0, 3));
         RegWriteE    = ($urandom_range(0, 3) == 0);
         RegWriteM    = ($urandom_range(0, 1) == 0);
         RegWriteW    = ($urandom_range(0, 1) == 0);
         MemtoRegE    = ($urandom_range(0, 3) == 0);
         BranchTakenE = ($urandom_range(0, 7) == 0);
         MemReqM      = ($urandom_range(0, 3) == 0) || (MemReqM && !MemReadyM && $urandom_range(0, 1) == 0);
         MemReadyM    = ($urandom_range(0, 2) == 0);
         if (n == 200) rst_n = 1'b0;
         if (n == 202) rst_n = 1'b1;
         next_cycle();
      end
      idle();
      next_cycle();
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter BR_FLUSH_CYCLES, default 2, is the number of consecutive cycles FlushD is asserted after a taken branch; legal range 1..7.
REQ-002 Parameter MEM_TIMEOUT, default 255, is the number of consecutive wait cycles after which MemErr is raised; legal range 1..255.
REQ-003 clk  in  1  single clock for all state; all registers update on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 RA1D, RA2D  in  4 each  source registers of the instruction in Decode.
REQ-006 RA1E, RA2E  in  4 each  source registers of the instruction in Execute.
REQ-007 WA3E, WA3M, WA3W  in  4 each  destination registers in Execute, Memory and Writeback.
REQ-008 RegWriteE, RegWriteM, RegWriteW  in  1 each  destination write enables per stage.
REQ-009 MemtoRegE  in  1  the instruction in Execute is a load.
REQ-010 BranchTakenE  in  1  branch resolved taken in Execute.
REQ-011 MemReqM, MemReadyM  in  1 each  data-memory access in Memory stage, and its completion.
REQ-012 StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register; each register's enable is the inverse of its stall.
REQ-013 FlushD, FlushE, FlushW  out  1 each  load zeros (bubble) into the F/D, D/E and M/W registers.
REQ-014 ForwardAE, ForwardBE  out  2 each  operand source select: 00 register file, 01 Writeback result, 10 Memory result.
REQ-015 MemErr  out  1  sticky memory-timeout flag.
REQ-016 State  out  2  current FSM state, for debug.

Function
REQ-017 The FSM SHALL have states RUN=00, BRFLUSH=01 and MEMWAIT=10; code 11 SHALL return to RUN on the next edge.
REQ-018 Priority SHALL be MEMWAIT, then branch flush, then load-use/RAW stall.
REQ-019 A memory wait SHALL exist whenever MemReqM=1 and MemReadyM=0; in that cycle StallF=StallD=StallE=StallM=1 and FlushW=1, with all other flushes 0.
REQ-020 The FSM SHALL enter MEMWAIT on a wait and return to its prior state (RUN or BRFLUSH) in the cycle after MemReadyM=1; the BRFLUSH counter SHALL be frozen during MEMWAIT.
REQ-021 An 8-bit wait counter SHALL increment on each wait cycle and clear when there is no wait; MemErr SHALL set when the counter reaches MEM_TIMEOUT and stay set until reset.
REQ-022 BranchTakenE=1 with no wait SHALL assert FlushD=1 and FlushE=1 in the same cycle, load BR_FLUSH_CYCLES-1 into a down-counter and enter BRFLUSH if that value is nonzero.
REQ-023 In BRFLUSH, FlushD SHALL stay 1 and the counter SHALL decrement each cycle; the FSM SHALL return to RUN when the counter reaches zero.
REQ-024 A taken branch while in BRFLUSH SHALL reload the counter.
REQ-025 A load-use hazard is MemtoRegE=1 with WA3E equal to RA1D or RA2D; in RUN it SHALL give StallF=StallD=1 and FlushE=1 for that cycle only.
REQ-026 If a branch and a load-use hazard occur in the same cycle, the branch SHALL win: no stall, with FlushD and FlushE asserted.
REQ-027 All Stall and Flush outputs SHALL be combinational from the current state and inputs; the counters, FSM state and MemErr SHALL be registered.

Reset
REQ-028 While reset_n=0 the block SHALL be in state RUN, both counters SHALL be 0, MemErr SHALL be 0, and every Stall, Flush and Forward output SHALL be 0, regardless of clk.
REQ-029 Asserting reset mid-MEMWAIT or mid-BRFLUSH SHALL abandon the sequence immediately; operation resumes in RUN from the first clk edge after reset_n rises.

Configuration
REQ-030 Macro FORWARD_EN defined: ForwardAE SHALL be 10 if RegWriteM=1 and WA3M=RA1E, else 01 if RegWriteW=1 and WA3W=RA1E, else 00; ForwardBE SHALL use the same rule with RA2E. The Memory stage has priority.
REQ-031 FORWARD_EN undefined: ForwardAE and ForwardBE SHALL be fixed at 00. Any RA1D/RA2D match against a destination with RegWriteE=1 or RegWriteM=1 SHALL be treated as a load-use hazard under REQ-025.

Verification
REQ-032 Load to R3 in Execute and RA1D=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then all outputs 0.
REQ-033 BranchTakenE pulse with BR_FLUSH_CYCLES=2 -> FlushD=1 for 2 cycles, FlushE=1 for the first cycle only, State 00->01->00.
REQ-034 MemReqM=1 and MemReadyM=0 for 3 cycles, then MemReadyM=1 -> all four stalls and FlushW high for 3 cycles, MemErr remains 0.
REQ-035 MEM_TIMEOUT=4 and MemReadyM held at 0 -> MemErr=1 after the 4th wait cycle and still 1 after the wait ends; reset_n=0 clears it.
REQ-036 FORWARD_EN defined, WA3M=WA3W=5 with both write enables 1, RA1E=5 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01.
REQ-037 Branch during MEMWAIT, then reset_n pulsed low -> outputs go to 0 asynchronously and State=00.
